game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
// Game sequencer for Duck Hunt. Drives the 3-bit display state, shot flash and shot count consumed by color_mapper.
// Counts shots, hits and ducks per round, and times each phase in video frames.
// Sits between input logic (trigger/hit detection, start button) and the VGA colour path.
// PARAMETERS
// SHOTS_PER_DUCK   3    trigger pulls allowed per duck
// DUCKS_PER_ROUND  10   ducks flown per round
// PASS_HITS        6    hits needed to advance to the next round
// INTRO_FRAMES     120  dog intro duration, frames
// FLIGHT_FRAMES    300  max flight time before the duck escapes, frames
// FALL_FRAMES      60   shot/fall animation, frames
// ESCAPE_FRAMES    60   escape animation, frames
// RETRIEVE_FRAMES  90   dog retrieve/laugh, frames
// OVER_FRAMES      240  game-over hold, frames
// FLASH_FRAMES     4    cursor flash length after an accepted trigger
// PORTS
// Clk         in   1  system clock
// Reset       in   1  asynchronous, active-high reset
// frame_tick  in   1  one-cycle pulse per frame (VS edge), synchronous to Clk
// start       in   1  start button, level, already synchronised
// trigger     in   1  one-cycle shot pulse
// hit         in   1  duck under cursor; sampled only with trigger
// state       out  3  000 TITLE, 001 INTRO, 010 FLIGHT, 011 OVER, 100 SHOT, 101 ESCAPE, 110 RETRIEVE
// shot        out  1  cursor flash active
// num_shots   out  3  shots used on the current duck (0..SHOTS_PER_DUCK)
// hits        out  4  ducks hit this round
// ducks_done  out  4  ducks completed this round
// round       out  4  round number, starts at 1, saturates at 15
// duck_launch out  1  one-cycle pulse: spawn new duck
// score_add   out  1  one-cycle pulse per hit
// BEHAVIOUR
// - Reset: state=TITLE. shot=0, num_shots=0, hits=0, ducks_done=0, round=1. Pulses low. Frame timer=0.
// - All outputs registered. State changes appear the cycle after the deciding edge.
// - start acts on its rising edge only (internal 1-flop edge detect). Held high does not retrigger.
// - Frame timer clears on every state entry and increments on frame_tick.
//   "Timeout N": frame_tick arrives while timer==N-1.
// - TITLE: start edge -> INTRO. Clears hits, ducks_done and num_shots. Sets round=1.
// - INTRO: timeout INTRO_FRAMES -> FLIGHT, with duck_launch pulsed on the same edge.
// - FLIGHT, trigger with num_shots<SHOTS_PER_DUCK:
//   - num_shots++; shot=1 for FLASH_FRAMES frame_ticks.
//   - If hit: -> SHOT, hits++, score_add pulse.
//   - Else if num_shots reaches SHOTS_PER_DUCK: -> ESCAPE.
//   - Triggers with shots exhausted, or outside FLIGHT, are ignored.
// - FLIGHT: timeout FLIGHT_FRAMES with no trigger in that cycle -> ESCAPE.
//   Trigger+timeout in the same cycle: the trigger is processed first; a hit wins.
// - SHOT: timeout FALL_FRAMES -> RETRIEVE. ESCAPE: timeout ESCAPE_FRAMES -> RETRIEVE.
// - RETRIEVE: on timeout RETRIEVE_FRAMES, ducks_done++ and num_shots=0. Then:
//   - If ducks_done+1 < DUCKS_PER_ROUND: -> FLIGHT, duck_launch pulse.
//   - Else if hits>=PASS_HITS: -> INTRO, round++ (saturate 15), hits=0, ducks_done=0.
//   - Else: -> OVER.
// - OVER: timeout OVER_FRAMES or start edge -> TITLE.
// - Encoding 111 (illegal) -> TITLE next cycle; counters untouched.
// - Shot flash: its own frame counter, independent of state. Re-arms on each accepted trigger.
//   Forced 0 on TITLE entry.
// - Counters never wrap: hits and ducks_done are bounded by DUCKS_PER_ROUND <= 15.
// - Reset mid-operation returns everything to reset values immediately (asynchronous).
// STRUCTURE
// - Package duck_pkg: state_t enum with the fixed 3-bit encodings above, default parameter constants.
//   color_mapper shares the same encodings.
// - Sub-module frame_timer: clear, tick and terminal-count inputs; done output.
//   Instanced once for phase timing, once for the shot flash.
// - Top level: FSM, start edge detect, shot/hit/duck/round counters.
// TESTING (bench params: INTRO=2, FLIGHT=5, FALL=ESCAPE=RETRIEVE=2, OVER=3, FLASH=2, DUCKS=2, PASS=1)
// - Reset, start pulse -> INTRO next cycle; 2 ticks -> FLIGHT with 1-cycle duck_launch; round=1.
// - FLIGHT, trigger hit=1 -> SHOT, hits=1, num_shots=1, score_add 1 cycle, shot high for 2 ticks.
// - FLIGHT, 3 triggers hit=0 -> ESCAPE after the 3rd; a 4th trigger is ignored; num_shots stays 3.
// - FLIGHT, trigger hit=1 in the same cycle as the 5th tick -> SHOT, not ESCAPE.
// - 2 ducks, 1 hit -> INTRO with round=2, hits=0. 2 ducks, 0 hits -> OVER, then TITLE after 3 ticks.
// - Assert Reset during FALL -> TITLE and all counters at reset values the same cycle; start held high does not restart.

Source files
------------

// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the Duck Hunt game sequencer and its colour path.
package game_state_ctrl_pkg;

  // Display state encodings; color_mapper decodes the same 3-bit values.
  typedef enum logic [2:0] {
    ST_TITLE    = 3'b000,
    ST_INTRO    = 3'b001,
    ST_FLIGHT   = 3'b010,
    ST_OVER     = 3'b011,
    ST_SHOT     = 3'b100,
    ST_ESCAPE   = 3'b101,
    ST_RETRIEVE = 3'b110
  } state_t;

  // Width of the frame counters; wide enough for any phase length in frames.
  localparam int TIMER_W = 16;

  // Default game tuning.
  localparam int DEF_SHOTS_PER_DUCK  = 3;
  localparam int DEF_DUCKS_PER_ROUND = 10;
  localparam int DEF_PASS_HITS       = 6;
  localparam int DEF_INTRO_FRAMES    = 120;
  localparam int DEF_FLIGHT_FRAMES   = 300;
  localparam int DEF_FALL_FRAMES     = 60;
  localparam int DEF_ESCAPE_FRAMES   = 60;
  localparam int DEF_RETRIEVE_FRAMES = 90;
  localparam int DEF_OVER_FRAMES     = 240;
  localparam int DEF_FLASH_FRAMES    = 4;

  // Increment a 4-bit counter, holding at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Handshake bundle between input logic, the game sequencer and the colour path.
interface game_state_ctrl_if;
  import game_state_ctrl_pkg::*;

  logic       frame_tick;
  logic       start;
  logic       trigger;
  logic       hit;
  state_t     state;
  logic       shot;
  logic [2:0] num_shots;
  logic [3:0] hits;
  logic [3:0] ducks_done;
  logic [3:0] round;
  logic       duck_launch;
  logic       score_add;

  // Driver side: input logic feeding the sequencer and observing its outputs.
  modport master (
    output frame_tick, start, trigger, hit,
    input  state, shot, num_shots, hits, ducks_done, round, duck_launch, score_add
  );

  // Sequencer side.
  modport slave (
    input  frame_tick, start, trigger, hit,
    output state, shot, num_shots, hits, ducks_done, round, duck_launch, score_add
  );
endinterface

// File: rtl/game_state_ctrl_frame_timer.sv
// Frame counter: clears on request, counts frame ticks, flags the tick that
// completes tc_i frames. done_o does not depend on clear_i so the caller can
// derive its clear from a decision that itself uses done_o.
module game_state_ctrl_frame_timer
  import game_state_ctrl_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear_i,
  input  logic               tick_i,
  input  logic [TIMER_W-1:0] tc_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: clear wins over tick; hold at all-ones rather than wrap.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {TIMER_W{1'b0}};
    end else if (tick_i && (count_q != {TIMER_W{1'b1}})) begin
      count_d = count_q + TIMER_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= {TIMER_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = tick_i && (count_q == (tc_i - TIMER_W'(1)));

endmodule

// File: rtl/game_state_ctrl.sv
// Duck Hunt game sequencer: phase FSM, start edge detect, shot flash and
// per-round shot/hit/duck/round bookkeeping. All outputs are registered.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int SHOTS_PER_DUCK  = DEF_SHOTS_PER_DUCK,
  parameter int DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
  parameter int PASS_HITS       = DEF_PASS_HITS,
  parameter int INTRO_FRAMES    = DEF_INTRO_FRAMES,
  parameter int FLIGHT_FRAMES   = DEF_FLIGHT_FRAMES,
  parameter int FALL_FRAMES     = DEF_FALL_FRAMES,
  parameter int ESCAPE_FRAMES   = DEF_ESCAPE_FRAMES,
  parameter int RETRIEVE_FRAMES = DEF_RETRIEVE_FRAMES,
  parameter int OVER_FRAMES     = DEF_OVER_FRAMES,
  parameter int FLASH_FRAMES    = DEF_FLASH_FRAMES
) (
  input logic               Clk,
  input logic               Reset,
  game_state_ctrl_if.slave  bus
);

  state_t             state_q, state_d;
  logic               start_q;
  logic               shot_q, shot_d;
  logic [2:0]         num_shots_q, num_shots_d;
  logic [3:0]         hits_q, hits_d;
  logic [3:0]         ducks_q, ducks_d;
  logic [3:0]         round_q, round_d;
  logic               launch_q, launch_d;
  logic               score_q, score_d;

  logic               start_rise_s;
  logic               trig_acc_s;
  logic               phase_clear_s;
  logic               phase_done_s;
  logic               flash_done_s;
  logic               last_duck_s;
  logic               title_entry_s;
  logic [TIMER_W-1:0] phase_tc_s;

  assign start_rise_s  = bus.start && !start_q;
  assign trig_acc_s    = (state_q == ST_FLIGHT) && bus.trigger &&
                         (num_shots_q < 3'(SHOTS_PER_DUCK));
  assign phase_clear_s = (state_d != state_q);
  assign title_entry_s = (state_d == ST_TITLE) && (state_q != ST_TITLE);
  assign last_duck_s   = !(({1'b0, ducks_q} + 5'd1) < 5'(DUCKS_PER_ROUND));

  // Phase length for the current state.
  always_comb begin
    phase_tc_s = {TIMER_W{1'b1}};
    case (state_q)
      ST_INTRO:    phase_tc_s = TIMER_W'(INTRO_FRAMES);
      ST_FLIGHT:   phase_tc_s = TIMER_W'(FLIGHT_FRAMES);
      ST_SHOT:     phase_tc_s = TIMER_W'(FALL_FRAMES);
      ST_ESCAPE:   phase_tc_s = TIMER_W'(ESCAPE_FRAMES);
      ST_RETRIEVE: phase_tc_s = TIMER_W'(RETRIEVE_FRAMES);
      ST_OVER:     phase_tc_s = TIMER_W'(OVER_FRAMES);
      default:     phase_tc_s = {TIMER_W{1'b1}};
    endcase
  end

  game_state_ctrl_frame_timer u_phase_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear_i (phase_clear_s),
    .tick_i  (bus.frame_tick),
    .tc_i    (phase_tc_s),
    .done_o  (phase_done_s)
  );

  // The flash timer restarts on every accepted trigger.
  game_state_ctrl_frame_timer u_flash_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear_i (trig_acc_s),
    .tick_i  (bus.frame_tick),
    .tc_i    (TIMER_W'(FLASH_FRAMES)),
    .done_o  (flash_done_s)
  );

  // State register plus all registered outputs. start_q resets high so a
  // button already held through reset is not seen as a fresh press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_TITLE;
      start_q     <= 1'b1;
      shot_q      <= 1'b0;
      num_shots_q <= 3'd0;
      hits_q      <= 4'd0;
      ducks_q     <= 4'd0;
      round_q     <= 4'd1;
      launch_q    <= 1'b0;
      score_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.start;
      shot_q      <= shot_d;
      num_shots_q <= num_shots_d;
      hits_q      <= hits_d;
      ducks_q     <= ducks_d;
      round_q     <= round_d;
      launch_q    <= launch_d;
      score_q     <= score_d;
    end
  end

  // Next-state decision. A trigger is resolved before a flight timeout; a
  // miss that coincides with the timeout still lets the duck escape.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TITLE: begin
        if (start_rise_s) state_d = ST_INTRO;
        else              state_d = state_q;
      end
      ST_INTRO: begin
        if (phase_done_s) state_d = ST_FLIGHT;
        else              state_d = state_q;
      end
      ST_FLIGHT: begin
        if (trig_acc_s && bus.hit) begin
          state_d = ST_SHOT;
        end else if (trig_acc_s && ((num_shots_q + 3'd1) == 3'(SHOTS_PER_DUCK))) begin
          state_d = ST_ESCAPE;
        end else if (phase_done_s) begin
          state_d = ST_ESCAPE;
        end else begin
          state_d = state_q;
        end
      end
      ST_SHOT, ST_ESCAPE: begin
        if (phase_done_s) state_d = ST_RETRIEVE;
        else              state_d = state_q;
      end
      ST_RETRIEVE: begin
        if (!phase_done_s)                   state_d = state_q;
        else if (!last_duck_s)               state_d = ST_FLIGHT;
        else if (hits_q >= 4'(PASS_HITS))    state_d = ST_INTRO;
        else                                 state_d = ST_OVER;
      end
      ST_OVER: begin
        if (phase_done_s || start_rise_s) state_d = ST_TITLE;
        else                              state_d = state_q;
      end
      default: state_d = ST_TITLE;
    endcase
  end

  // Counter, flash and pulse updates that accompany each transition.
  always_comb begin
    num_shots_d = num_shots_q;
    hits_d      = hits_q;
    ducks_d     = ducks_q;
    round_d     = round_q;
    launch_d    = 1'b0;
    score_d     = 1'b0;
    case (state_q)
      ST_TITLE: begin
        if (start_rise_s) begin
          num_shots_d = 3'd0;
          hits_d      = 4'd0;
          ducks_d     = 4'd0;
          round_d     = 4'd1;
        end else begin
          round_d     = round_q;
        end
      end
      ST_INTRO: begin
        if (phase_done_s) launch_d = 1'b1;
        else              launch_d = 1'b0;
      end
      ST_FLIGHT: begin
        if (trig_acc_s) begin
          num_shots_d = num_shots_q + 3'd1;
          if (bus.hit) begin
            hits_d  = hits_q + 4'd1;
            score_d = 1'b1;
          end else begin
            score_d = 1'b0;
          end
        end else begin
          num_shots_d = num_shots_q;
        end
      end
      ST_RETRIEVE: begin
        if (phase_done_s) begin
          num_shots_d = 3'd0;
          ducks_d     = ducks_q + 4'd1;
          if (!last_duck_s) begin
            launch_d = 1'b1;
          end else if (hits_q >= 4'(PASS_HITS)) begin
            round_d = sat_inc4(round_q);
            hits_d  = 4'd0;
            ducks_d = 4'd0;
          end else begin
            launch_d = 1'b0;
          end
        end else begin
          ducks_d = ducks_q;
        end
      end
      default: begin
        num_shots_d = num_shots_q;
      end
    endcase

    if (title_entry_s)                shot_d = 1'b0;
    else if (trig_acc_s)              shot_d = 1'b1;
    else if (shot_q && flash_done_s)  shot_d = 1'b0;
    else                              shot_d = shot_q;
  end

  assign bus.state       = state_q;
  assign bus.shot        = shot_q;
  assign bus.num_shots   = num_shots_q;
  assign bus.hits        = hits_q;
  assign bus.ducks_done  = ducks_q;
  assign bus.round       = round_q;
  assign bus.duck_launch = launch_q;
  assign bus.score_add   = score_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed, table-driven bench for game_state_ctrl with shortened phases.
module tb_game_state_ctrl;
  import game_state_ctrl_pkg::*;

  logic Clk;
  logic Reset;
  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .SHOTS_PER_DUCK  (3),
    .DUCKS_PER_ROUND (2),
    .PASS_HITS       (1),
    .INTRO_FRAMES    (2),
    .FLIGHT_FRAMES   (5),
    .FALL_FRAMES     (2),
    .ESCAPE_FRAMES   (2),
    .RETRIEVE_FRAMES (2),
    .OVER_FRAMES     (3),
    .FLASH_FRAMES    (2)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // inputs packed {start, trigger, hit, frame_tick}
  // outputs packed {state, shot, num_shots, hits, ducks_done, round, duck_launch, score_add}
  typedef struct {
    logic [3:0]  in;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [20:0] mk(input state_t s, input int sh, input int ns, input int h,
                                     input int d, input int r, input int dl, input int sa);
    return {s, 1'(sh), 3'(ns), 4'(h), 4'(d), 4'(r), 1'(dl), 1'(sa)};
  endfunction

  function automatic logic [20:0] outs();
    return {bus.state, bus.shot, bus.num_shots, bus.hits, bus.ducks_done, bus.round,
            bus.duck_launch, bus.score_add};
  endfunction

  task automatic add(input logic [3:0] in, input logic [20:0] exp, input int n);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got st=%0d sh=%0d ns=%0d hits=%0d ducks=%0d rnd=%0d dl=%0d sa=%0d, want st=%0d sh=%0d ns=%0d hits=%0d ducks=%0d rnd=%0d dl=%0d sa=%0d",
               name, act[20:18], act[17], act[16:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
               exp[20:18], exp[17], exp[16:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [3:0] in);
    bus.start      = in[3];
    bus.trigger    = in[2];
    bus.hit        = in[1];
    bus.frame_tick = in[0];
  endtask

  task automatic step(input logic [3:0] in, input logic [20:0] exp, input string name);
    @(negedge Clk);
    drive(in);
    @(posedge Clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    logic [20:0] rst_vec;
    rst_vec = mk(ST_TITLE, 0, 0, 0, 0, 1, 0, 0);
    Reset = 1'b1;
    drive(4'b0000);
    #22;
    check("reset_state", rst_vec);
    @(negedge Clk);
    Reset = 1'b0;

    // Round 1: duck 1 hit on first shot, duck 2 missed three times.
    add(4'b0000, mk(ST_TITLE,    0,0,0,0,1,0,0), 1);
    add(4'b1000, mk(ST_INTRO,    0,0,0,0,1,0,0), 1);
    add(4'b0001, mk(ST_INTRO,    0,0,0,0,1,0,0), 1);
    add(4'b0001, mk(ST_FLIGHT,   0,0,0,0,1,1,0), 1);
    add(4'b0000, mk(ST_FLIGHT,   0,0,0,0,1,0,0), 1);
    add(4'b0110, mk(ST_SHOT,     1,1,1,0,1,0,1), 1);
    add(4'b0000, mk(ST_SHOT,     1,1,1,0,1,0,0), 1);
    add(4'b0001, mk(ST_SHOT,     1,1,1,0,1,0,0), 1);
    add(4'b0001, mk(ST_RETRIEVE, 0,1,1,0,1,0,0), 2);
    add(4'b0001, mk(ST_FLIGHT,   0,0,1,1,1,1,0), 1);
    add(4'b0100, mk(ST_FLIGHT,   1,1,1,1,1,0,0), 1);
    add(4'b0100, mk(ST_FLIGHT,   1,2,1,1,1,0,0), 1);
    add(4'b0100, mk(ST_ESCAPE,   1,3,1,1,1,0,0), 2);
    add(4'b0001, mk(ST_ESCAPE,   1,3,1,1,1,0,0), 1);
    add(4'b0001, mk(ST_RETRIEVE, 0,3,1,1,1,0,0), 2);
    // Round 2: hit on the same cycle as the flight timeout, then a timeout escape.
    add(4'b0001, mk(ST_INTRO,    0,0,0,0,2,0,0), 2);
    add(4'b0001, mk(ST_FLIGHT,   0,0,0,0,2,1,0), 1);
    add(4'b0001, mk(ST_FLIGHT,   0,0,0,0,2,0,0), 4);
    add(4'b0111, mk(ST_SHOT,     1,1,1,0,2,0,1), 1);
    add(4'b0001, mk(ST_SHOT,     1,1,1,0,2,0,0), 1);
    add(4'b0001, mk(ST_RETRIEVE, 0,1,1,0,2,0,0), 2);
    add(4'b0001, mk(ST_FLIGHT,   0,0,1,1,2,1,0), 1);
    add(4'b0001, mk(ST_FLIGHT,   0,0,1,1,2,0,0), 4);
    add(4'b0001, mk(ST_ESCAPE,   0,0,1,1,2,0,0), 2);
    add(4'b0001, mk(ST_RETRIEVE, 0,0,1,1,2,0,0), 2);
    // Round 3: both ducks escape, game over, then back to title.
    add(4'b0001, mk(ST_INTRO,    0,0,0,0,3,0,0), 2);
    add(4'b0001, mk(ST_FLIGHT,   0,0,0,0,3,1,0), 1);
    add(4'b0001, mk(ST_FLIGHT,   0,0,0,0,3,0,0), 4);
    add(4'b0001, mk(ST_ESCAPE,   0,0,0,0,3,0,0), 2);
    add(4'b0001, mk(ST_RETRIEVE, 0,0,0,0,3,0,0), 2);
    add(4'b0001, mk(ST_FLIGHT,   0,0,0,1,3,1,0), 1);
    add(4'b0001, mk(ST_FLIGHT,   0,0,0,1,3,0,0), 4);
    add(4'b0001, mk(ST_ESCAPE,   0,0,0,1,3,0,0), 2);
    add(4'b0001, mk(ST_RETRIEVE, 0,0,0,1,3,0,0), 2);
    add(4'b0001, mk(ST_OVER,     0,0,0,2,3,0,0), 3);
    add(4'b0001, mk(ST_TITLE,    0,0,0,2,3,0,0), 1);
    // New game: counters cleared, start held high.
    add(4'b1000, mk(ST_INTRO,    0,0,0,0,1,0,0), 1);
    add(4'b1001, mk(ST_INTRO,    0,0,0,0,1,0,0), 1);
    add(4'b1001, mk(ST_FLIGHT,   0,0,0,0,1,1,0), 1);

    foreach (vecs[i]) begin
      step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset asserted mid-fall with start held high.
    step(4'b1110, mk(ST_SHOT, 1,1,1,0,1,0,1), "fall_enter");
    step(4'b1001, mk(ST_SHOT, 1,1,1,0,1,0,0), "fall_tick");
    @(negedge Clk);
    drive(4'b1000);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset", rst_vec);
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(4'b1000, rst_vec, $sformatf("held_start%0d", k));
    end
    step(4'b0000, rst_vec, "start_release");
    step(4'b1000, mk(ST_INTRO, 0,0,0,0,1,0,0), "start_again");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
